// File: rtl/edge_detector_array.sv
// Multi-channel edge detector: per-channel synchronizer, programmable glitch filter,
// rising/falling pulses, and sticky write-1-to-clear pending flags ORed into one interrupt.
module edge_detector_array #(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   a_i,
    input  logic [FILTER_W-1:0] filter_len_i,
    input  logic [NUM_CH-1:0]   rise_en_i,
    input  logic [NUM_CH-1:0]   fall_en_i,
    input  logic [NUM_CH-1:0]   clr_i,
    output logic [NUM_CH-1:0]   level_o,
    output logic [NUM_CH-1:0]   rising_edge_o,
    output logic [NUM_CH-1:0]   falling_edge_o,
    output logic [NUM_CH-1:0]   pending_o,
    output logic                irq_o
);

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0]                  sync_s;
    logic [NUM_CH-1:0]                  level_q, level_d;
    logic [NUM_CH-1:0]                  level_dly_q;
    logic [NUM_CH-1:0][FILTER_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]                  pend_q, pend_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Filter: a new level must persist for filter_len_i+1 consecutive cycles.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int ch = 0; ch < int'(NUM_CH); ch++) begin
            if (sync_s[ch] == level_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] >= filter_len_i) begin
                level_d[ch] = sync_s[ch];
                cnt_d[ch]   = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + FILTER_W'(1);
            end
        end
    end

    // Set has priority over a simultaneous clear.
    always_comb begin
        pend_d = (rising_edge_o & rise_en_i) | (falling_edge_o & fall_en_i)
               | (pend_q & ~clr_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            cnt_q       <= '0;
            pend_q      <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], a_i};
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
        end
    end

    assign level_o        = level_q;
    assign rising_edge_o  = level_q & ~level_dly_q;
    assign falling_edge_o = ~level_q & level_dly_q;
    assign pending_o      = pend_q;
    assign irq_o          = |pend_q;

endmodule

// File: tb/tb_edge_detector_array.sv
// Directed bench for edge_detector_array: a per-cycle reference model plus hand-timed checks.
module tb_edge_detector_array;

    localparam int unsigned NUM_CH      = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILTER_W    = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NUM_CH-1:0]   a_i = '0;
    logic [FILTER_W-1:0] filter_len_i = '0;
    logic [NUM_CH-1:0]   rise_en_i = '0;
    logic [NUM_CH-1:0]   fall_en_i = '0;
    logic [NUM_CH-1:0]   clr_i = '0;
    logic [NUM_CH-1:0]   level_o, rising_edge_o, falling_edge_o, pending_o;
    logic                irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    edge_detector_array #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .FILTER_W(FILTER_W)
    ) dut (
        .clk(clk), .reset(reset), .a_i(a_i), .filter_len_i(filter_len_i),
        .rise_en_i(rise_en_i), .fall_en_i(fall_en_i), .clr_i(clr_i),
        .level_o(level_o), .rising_edge_o(rising_edge_o), .falling_edge_o(falling_edge_o),
        .pending_o(pending_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: pipe of raw samples, then a run-length rule on the filtered level.
    logic [NUM_CH-1:0] m_sync [SYNC_STAGES];
    logic [NUM_CH-1:0] m_f, m_fd, m_pend, nf;
    int                m_run [NUM_CH];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) m_sync[i] <= '0;
            m_f    <= '0;
            m_fd   <= '0;
            m_pend <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) m_run[c] <= 0;
        end else begin
            nf = m_f;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (m_sync[SYNC_STAGES-1][c] != m_f[c]) begin
                    if (m_run[c] + 1 >= int'(filter_len_i) + 1) begin
                        nf[c] = m_sync[SYNC_STAGES-1][c];
                        m_run[c] <= 0;
                    end else begin
                        m_run[c] <= m_run[c] + 1;
                    end
                end else begin
                    m_run[c] <= 0;
                end
            end
            m_f    <= nf;
            m_fd   <= m_f;
            m_pend <= ((m_f & ~m_fd) & rise_en_i) | ((~m_f & m_fd) & fall_en_i)
                    | (m_pend & ~clr_i);
            m_sync[0] <= a_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) m_sync[i] <= m_sync[i-1];
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_level", level_o, m_f);
        chk("model_rise", rising_edge_o, m_f & ~m_fd);
        chk("model_fall", falling_edge_o, ~m_f & m_fd);
        chk("model_pend", pending_o, m_pend);
        chk("model_irq", irq_o, |m_pend);
    end

    // Stimulus changes land 2 time units after an edge, away from sampling.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        step(2);
        chk("rst_level", level_o, 0);
        chk("rst_pend", pending_o, 0);
        chk("rst_irq", irq_o, 0);
        reset = 1'b0;
        step(2);

        // Ch0, L=0: pulse between edges 3 and 4, pending from edge 4.
        a_i[0] = 1'b1; rise_en_i[0] = 1'b1;
        step(1); chk("t1_rise_e1", rising_edge_o[0], 0);
        step(1); chk("t1_rise_e2", rising_edge_o[0], 0);
        step(1); chk("t1_level_e3", level_o[0], 1);
        chk("t1_rise_e3", rising_edge_o[0], 1);
        chk("t1_pend_e3", pending_o[0], 0);
        step(1); chk("t1_rise_e4", rising_edge_o[0], 0);
        chk("t1_pend_e4", pending_o[0], 1);
        chk("t1_irq_e4", irq_o, 1);

        // Ch1, L=3: 3-cycle glitch is rejected, 4-cycle hold is accepted.
        filter_len_i = 4'd3; rise_en_i[1] = 1'b1;
        a_i[1] = 1'b1;
        step(3);
        a_i[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t2_glitch_level", level_o[1], 0);
            chk("t2_glitch_rise", rising_edge_o[1], 0);
        end
        a_i[1] = 1'b1;
        step(5); chk("t2_level_e5", level_o[1], 0);
        step(1); chk("t2_level_e6", level_o[1], 1);
        chk("t2_rise_e6", rising_edge_o[1], 1);
        step(1); chk("t2_rise_e7", rising_edge_o[1], 0);
        chk("t2_pend_e7", pending_o[1], 1);

        // Ch2: only the falling edge is enabled.
        filter_len_i = 4'd0; fall_en_i[2] = 1'b1; rise_en_i[2] = 1'b0;
        a_i[2] = 1'b1;
        step(3); chk("t3_rise", rising_edge_o[2], 1);
        step(1); chk("t3_pend_after_rise", pending_o[2], 0);
        a_i[2] = 1'b0;
        step(3); chk("t3_fall", falling_edge_o[2], 1);
        chk("t3_no_rise", rising_edge_o[2], 0);
        step(1); chk("t3_pend_after_fall", pending_o[2], 1);

        // Ch3: set beats a simultaneous clear; a lone clear then drops it.
        clr_i = '1;
        step(1);
        clr_i = '0;
        chk("t4_clear_all", pending_o, 0);
        chk("t4_irq_low", irq_o, 0);
        rise_en_i[3] = 1'b1; fall_en_i[3] = 1'b1;
        a_i[3] = 1'b1;
        step(4); chk("t4_pend_set", pending_o[3], 1);
        a_i[3] = 1'b0;
        step(3); chk("t4_fall", falling_edge_o[3], 1);
        clr_i[3] = 1'b1;
        step(1); chk("t4_set_wins", pending_o[3], 1);
        step(1); chk("t4_cleared", pending_o[3], 0);
        chk("t4_irq_drop", irq_o, 0);
        clr_i[3] = 1'b0;

        // Ch4: lowering L mid-count releases the counter on the next edge.
        filter_len_i = 4'd15;
        a_i[4] = 1'b1;
        step(12); chk("t5_level_cnt10", level_o[4], 0);
        filter_len_i = 4'd2;
        step(1); chk("t5_level_now", level_o[4], 1);
        chk("t5_rise_now", rising_edge_o[4], 1);
        step(1); chk("t5_rise_gone", rising_edge_o[4], 0);

        // Reset mid-count with all inputs high.
        fall_en_i = '0; rise_en_i = '1;
        a_i = '0;
        step(8);
        a_i = '1;
        step(3);
        reset = 1'b1;
        #1;
        chk("t6_rst_level", level_o, 0);
        chk("t6_rst_pend", pending_o, 0);
        chk("t6_rst_irq", irq_o, 0);
        step(2);
        reset = 1'b0;
        #1;
        chk("t6_rel_level", level_o, 0);
        chk("t6_rel_rise", rising_edge_o, 0);
        #0;
        step(4); chk("t6_level_e4", level_o, 0);
        step(1); chk("t6_rise_e5", rising_edge_o, 8'hFF);
        chk("t6_level_e5", level_o, 8'hFF);
        step(1); chk("t6_pend_e6", pending_o, 8'hFF);
        chk("t6_irq_e6", irq_o, 1);
        chk("t6_rise_e6", rising_edge_o, 0);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
